// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router ingress: frames {len,addr} header, payload popped
// from a show-ahead buffer, and an XOR parity byte, then reports the router's error flag.
module router_pkt_tx #(
   parameter int ERR_WIN = 3,
   parameter int IFG     = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_addr,
   input  logic [5:0] cmd_len,
   input  logic       cmd_bad_par,
   input  logic [7:0] pl_data,
   input  logic [6:0] pl_avail,
   output logic       pl_rd,
   input  logic       busy,
   input  logic       error,
   output logic       pkt_valid,
   output logic [7:0] tx_data,
   output logic       done,
   output logic       pkt_err,
   output logic       cmd_rej
);

   localparam int WAIT_CYC = (IFG > ERR_WIN) ? IFG : ERR_WIN;
   localparam int WW       = $clog2(WAIT_CYC + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);
   localparam logic [WW-1:0] ERR_LIM   = WW'(ERR_WIN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_PARITY,
      S_WAIT
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      addr_q, addr_d;
   logic [5:0]      len_q, len_d;
   logic            bad_q, bad_d;
   logic [5:0]      rem_q, rem_d;
   logic [7:0]      par_q, par_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic            err_acc_q, err_acc_d;
   logic            done_q, done_d;
   logic            pkt_err_q, pkt_err_d;
   logic            cmd_rej_q, cmd_rej_d;

   logic            cmd_legal;
   logic            cmd_illegal;
   logic            avail_ok;
   logic            accept;
   logic            err_now;
   logic [7:0]      hdr_byte;

   assign cmd_legal   = cmd_valid && (cmd_addr != 2'd3) && (cmd_len != 6'd0);
   assign cmd_illegal = cmd_valid && ((cmd_addr == 2'd3) || (cmd_len == 6'd0));
   assign avail_ok    = pl_avail >= {1'b0, cmd_len};
   assign accept      = ~busy;
   assign hdr_byte    = {len_q, addr_q};

   assign done    = done_q;
   assign pkt_err = pkt_err_q;
   assign cmd_rej = cmd_rej_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         addr_q    <= 2'd0;
         len_q     <= 6'd0;
         bad_q     <= 1'b0;
         rem_q     <= 6'd0;
         par_q     <= 8'd0;
         wcnt_q    <= '0;
         err_acc_q <= 1'b0;
         done_q    <= 1'b0;
         pkt_err_q <= 1'b0;
         cmd_rej_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         bad_q     <= bad_d;
         rem_q     <= rem_d;
         par_q     <= par_d;
         wcnt_q    <= wcnt_d;
         err_acc_q <= err_acc_d;
         done_q    <= done_d;
         pkt_err_q <= pkt_err_d;
         cmd_rej_q <= cmd_rej_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      bad_d     = bad_q;
      rem_d     = rem_q;
      par_d     = par_q;
      wcnt_d    = wcnt_q;
      err_acc_d = err_acc_q;
      done_d    = 1'b0;
      pkt_err_d = 1'b0;
      cmd_rej_d = 1'b0;
      err_now   = 1'b0;
      cmd_ready = 1'b0;
      pkt_valid = 1'b0;
      tx_data   = 8'd0;
      pl_rd     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            // A legal command without enough buffered payload simply waits.
            if (cmd_illegal) begin
               cmd_rej_d = 1'b1;
            end else if (cmd_legal && avail_ok) begin
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               bad_d   = cmd_bad_par;
               state_d = S_HEADER;
            end
         end

         S_HEADER: begin
            pkt_valid = 1'b1;
            tx_data   = hdr_byte;
            if (accept) begin
               par_d   = hdr_byte;
               rem_d   = len_q;
               state_d = S_PAYLOAD;
            end
         end

         S_PAYLOAD: begin
            pkt_valid = 1'b1;
            tx_data   = pl_data;
            pl_rd     = accept;
            if (accept) begin
               par_d = par_q ^ pl_data;
               rem_d = rem_q - 6'd1;
               if (rem_q == 6'd1) begin
                  state_d = S_PARITY;
               end
            end
         end

         S_PARITY: begin
            tx_data = par_q ^ {8{bad_q}};
            if (accept) begin
               wcnt_d    = '0;
               err_acc_d = 1'b0;
               state_d   = S_WAIT;
            end
         end

         S_WAIT: begin
            // Gap timer runs regardless of busy: nothing is on the bus here.
            wcnt_d  = wcnt_q + 1'b1;
            err_now = err_acc_q | ((wcnt_q < ERR_LIM) & error);
            err_acc_d = err_now;
            if (wcnt_q == WAIT_LAST) begin
               done_d    = 1'b1;
               pkt_err_d = err_now;
               state_d   = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus queues expected packets, a negedge
// monitor compares the bus, pop strobes, done/pkt_err and rejects against them.
module tb_router_pkt_tx;

   localparam int ERR_WIN = 3;
   localparam int IFG     = 2;
   localparam int GAP     = (IFG > ERR_WIN) ? IFG : ERR_WIN;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_addr = 2'd0;
   logic [5:0] cmd_len = 6'd0;
   logic       cmd_bad_par = 1'b0;
   logic [7:0] pl_data = 8'h00;
   logic [6:0] pl_avail = 7'd0;
   logic       pl_rd;
   logic       busy = 1'b0;
   logic       error = 1'b0;
   logic       pkt_valid;
   logic [7:0] tx_data;
   logic       done;
   logic       pkt_err;
   logic       cmd_rej;

   router_pkt_tx #(.ERR_WIN(ERR_WIN), .IFG(IFG)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .cmd_bad_par(cmd_bad_par),
      .pl_data    (pl_data),
      .pl_avail   (pl_avail),
      .pl_rd      (pl_rd),
      .busy       (busy),
      .error      (error),
      .pkt_valid  (pkt_valid),
      .tx_data    (tx_data),
      .done       (done),
      .pkt_err    (pkt_err),
      .cmd_rej    (cmd_rej)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] up_q[$];
   logic [7:0] exp_byte_q[$];
   int         exp_len_q[$];
   bit         exp_bad_q[$];
   logic [7:0] cur_bytes[$];
   logic [7:0] pay [0:63];

   int rej_cd = 0;
   int done_cd = 0;
   bit pend_err = 0;
   int err_cd = 0;
   int force_d = 0;
   bit pop_pend = 0;
   int busy_mode = 0;
   int burst_left = 0;
   bit in_pkt = 0;
   int mon_idx = 0;
   int cur_len = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic refresh();
      pl_data  = (up_q.size() > 0) ? up_q[0] : 8'h00;
      pl_avail = (up_q.size() > 127) ? 7'd127 : 7'(up_q.size());
   endtask

   // Upstream buffer, busy and router error driver
   initial begin
      logic [7:0] tmp;
      forever begin
         @(posedge clk);
         #1;
         if (pop_pend) begin
            if (up_q.size() > 0) tmp = up_q.pop_front();
            pop_pend = 0;
            refresh();
         end
         if (err_cd > 0) begin
            err_cd--;
            error = (err_cd == 0);
         end else begin
            error = 1'b0;
         end
         case (busy_mode)
            1: busy = ($urandom_range(0, 3) == 0);
            2: begin
               if (in_pkt && mon_idx == 2 && burst_left > 0) begin
                  busy = 1'b1;
                  burst_left--;
               end else begin
                  busy = 1'b0;
               end
            end
            default: busy = 1'b0;
         endcase
      end
   end

   // Monitor
   initial begin
      bit exp_done, exp_rej;
      int d;
      forever begin
         @(negedge clk);
         pop_pend = pl_rd;
         if (!resetn) begin
            in_pkt = 0;
            mon_idx = 0;
            done_cd = 0;
            err_cd = 0;
            rej_cd = 0;
            exp_byte_q.delete();
            exp_len_q.delete();
            exp_bad_q.delete();
            cur_bytes.delete();
         end else begin
            exp_done = 0;
            if (done_cd > 0) begin
               done_cd--;
               exp_done = (done_cd == 0);
            end
            if (done || exp_done) begin
               chk("done_timing", done, exp_done);
               if (done && exp_done) chk("pkt_err", pkt_err, pend_err);
            end
            exp_rej = 0;
            if (rej_cd > 0) begin
               rej_cd--;
               exp_rej = (rej_cd == 0);
            end
            if (cmd_rej || exp_rej) chk("cmd_rej", cmd_rej, exp_rej);

            if (!in_pkt && pkt_valid) begin
               if (exp_len_q.size() == 0) begin
                  chk("unexpected_pkt", pkt_valid, 0);
               end else begin
                  cur_len = exp_len_q.pop_front();
                  void'(exp_bad_q.pop_front());
                  cur_bytes.delete();
                  for (int i = 0; i < cur_len + 2; i++) cur_bytes.push_back(exp_byte_q.pop_front());
                  in_pkt = 1;
                  mon_idx = 0;
               end
            end

            if (in_pkt) begin
               chk("tx_data", tx_data, cur_bytes[mon_idx]);
               chk("pkt_valid", pkt_valid, mon_idx <= cur_len);
               chk("pl_rd", pl_rd, (mon_idx >= 1) && (mon_idx <= cur_len) && !busy);
               if (!busy) begin
                  if (mon_idx == cur_len + 1) begin
                     in_pkt = 0;
                     done_cd = GAP + 1;
                     pend_err = 0;
                     if (force_d > 0 || $urandom_range(0, 2) == 0) begin
                        d = (force_d > 0) ? force_d : int'($urandom_range(1, GAP + 2));
                        err_cd = d;
                        pend_err = (d <= ERR_WIN);
                     end
                  end
                  mon_idx++;
               end
            end else begin
               chk("idle_tx_data", tx_data, 0);
               chk("idle_pl_rd", pl_rd, 0);
            end
         end
      end
   end

   task automatic rand_pay(input int l);
      for (int i = 0; i < l; i++) pay[i] = 8'($urandom);
   endtask

   task automatic push_expect(input logic [1:0] a, input logic [5:0] l, input bit b);
      logic [7:0] par;
      par = {l, a};
      exp_byte_q.push_back(par);
      for (int i = 0; i < int'(l); i++) begin
         exp_byte_q.push_back(pay[i]);
         par = par ^ pay[i];
      end
      exp_byte_q.push_back(b ? ~par : par);
      exp_len_q.push_back(int'(l));
      exp_bad_q.push_back(b);
   endtask

   task automatic send(input logic [1:0] a, input logic [5:0] l, input bit b, input int pre,
                       output bit acc_done);
      bit legal, found;
      legal = (a != 2'd3) && (l != 6'd0);
      acc_done = 0;
      found = 0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr = a;
      cmd_len = l;
      cmd_bad_par = b;
      if (legal) begin
         for (int i = 0; i < pre && i < int'(l); i++) up_q.push_back(pay[i]);
         if (pre >= int'(l)) push_expect(a, l, b);
         refresh();
         if (pre < int'(l)) begin
            repeat (6) @(negedge clk);
            chk("wait_no_rej", cmd_rej, 0);
            @(posedge clk);
            #1;
            for (int i = pre; i < int'(l); i++) up_q.push_back(pay[i]);
            push_expect(a, l, b);
            refresh();
         end
      end
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (cmd_ready && (!legal || pl_avail >= {1'b0, l})) begin
            acc_done = done;
            found = 1;
            break;
         end
      end
      if (!found) chk("cmd_accept_timeout", found, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (!legal) rej_cd = 1;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (exp_len_q.size() == 0 && !in_pkt && done_cd == 0 && rej_cd == 0 && cmd_ready) begin
            ok = 1;
            break;
         end
      end
      chk("wait_idle", ok, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pkt_valid"}, pkt_valid, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
      chk({tag, "_pl_rd"}, pl_rd, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pkt_err"}, pkt_err, 0);
      chk({tag, "_cmd_rej"}, cmd_rej, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask

   initial begin
      bit acc;
      bit found;
      int l;
      int watch;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");

      // Directed packet: addr=1 len=3 A1 B2 C3 -> 0D A1 B2 C3 DD
      pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
      send(2'd1, 6'd3, 1'b0, 3, acc);
      wait_idle();

      // Same packet with a two-cycle busy stall on B2
      busy_mode = 2;
      burst_left = 2;
      send(2'd1, 6'd3, 1'b0, 3, acc);
      wait_idle();
      busy_mode = 0;

      // Inverted parity (0x22) with router error two cycles after parity
      force_d = 2;
      send(2'd1, 6'd3, 1'b1, 3, acc);
      wait_idle();
      force_d = 0;

      // Rejects
      send(2'd3, 6'd3, 1'b0, 0, acc);
      wait_idle();
      send(2'd1, 6'd0, 1'b0, 0, acc);
      wait_idle();

      // Insufficient upstream data: command waits, no reject
      rand_pay(5);
      send(2'd0, 6'd5, 1'b0, 2, acc);
      wait_idle();

      // Maximum length, then back-to-back command accepted on the done cycle
      rand_pay(63);
      send(2'd2, 6'd63, 1'b0, 63, acc);
      rand_pay(10);
      send(2'd0, 6'd10, 1'b0, 10, acc);
      chk("b2b_accept_on_done", acc, 1);
      wait_idle();

      // Reset during payload of a 5-byte packet
      rand_pay(5);
      send(2'd0, 6'd5, 1'b0, 5, acc);
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (up_q.size() == 3) begin
            found = 1;
            break;
         end
      end
      chk("reset_point_reached", found, 1);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      up_q.delete();
      refresh();
      @(negedge clk);
      check_reset_outputs("midpkt_reset");
      repeat (8) @(negedge clk);
      rand_pay(4);
      send(2'd2, 6'd4, 1'b0, 4, acc);
      wait_idle();

      // Randomized traffic with random backpressure and error injection
      busy_mode = 1;
      for (int k = 0; k < 40; k++) begin
         l = $urandom_range(0, 63);
         rand_pay(l);
         send(2'($urandom_range(0, 3)), 6'(l), 1'($urandom_range(0, 1)), l, acc);
      end
      wait_idle();
      busy_mode = 0;
      repeat (5) @(negedge clk);
      chk("upstream_drained", up_q.size(), 0);
      watch = exp_byte_q.size();
      chk("scoreboard_empty", watch, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
